// File: rtl/snake_dir_ctrl.sv
// Snake direction controller: sync + debounce five buttons, filter reversals, queue commands per tick.
// Optional macro SNAKE_DIR_REVERSE_EN drops the opposite-direction filter (debug/easy mode).
module snake_dir_ctrl #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int QUEUE_DEPTH     = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         up,
  input  logic                         down,
  input  logic                         left,
  input  logic                         right,
  input  logic                         center,
  input  logic                         tick,
  output logic [4:0]                   go,
  output logic                         restart_pulse,
  output logic [$clog2(QUEUE_DEPTH):0] q_count,
  output logic                         overflow
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int PW = $clog2(QUEUE_DEPTH);
  localparam int NW = PW + 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  // Direction codes: 0 up, 1 down, 2 left, 3 right; code^1 is the opposite direction.
  function automatic logic [4:0] dir_onehot(input logic [1:0] code);
    case (code)
      2'd0:    return 5'b00001;
      2'd1:    return 5'b00010;
      2'd2:    return 5'b00100;
      2'd3:    return 5'b01000;
      default: return 5'b00000;
    endcase
  endfunction

  logic [4:0]    sync1_q, sync1_d, sync2_q, sync2_d;
  logic [4:0]    deb_q, deb_d, deb_dly_q, deb_dly_d;
  logic [CW-1:0] cnt_q [5];
  logic [CW-1:0] cnt_d [5];
  logic [1:0]    mem_q [QUEUE_DEPTH];
  logic [1:0]    mem_d [QUEUE_DEPTH];
  logic [PW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [NW-1:0] q_count_q, q_count_d;
  logic [4:0]    go_q, go_d;
  logic          restart_q, restart_d, overflow_q, overflow_d;

  logic [4:0] rise_s;
  logic       dir_ev_s, ctr_ev_s, go_ref_vld_s, ref_vld_s;
  logic       dup_s, rev_s, accept_s, full_s, push_s, pop_s;
  logic [1:0] dir_code_s, go_ref_code_s, tail_code_s, ref_code_s;

  // Synchroniser pipeline and per-button debounce counters.
  always_comb begin
    sync1_d   = {center, right, left, down, up};
    sync2_d   = sync1_q;
    deb_d     = deb_q;
    deb_dly_d = deb_q;
    cnt_d     = cnt_q;
    for (int i = 0; i < 5; i++) begin
      if (sync2_q[i] != deb_q[i]) begin
        if (cnt_q[i] == CNT_MAX) begin
          deb_d[i] = sync2_q[i];
          cnt_d[i] = '0;
        end else begin
          cnt_d[i] = cnt_q[i] + CW'(1);
        end
      end else begin
        cnt_d[i] = '0;
      end
    end
  end

  assign rise_s = deb_q & ~deb_dly_q;

  // Fixed-priority pick of one press event: up > down > left > right > center.
  always_comb begin
    dir_ev_s   = 1'b0;
    ctr_ev_s   = 1'b0;
    dir_code_s = 2'd0;
    if (rise_s[0]) begin
      dir_ev_s   = 1'b1;
      dir_code_s = 2'd0;
    end else if (rise_s[1]) begin
      dir_ev_s   = 1'b1;
      dir_code_s = 2'd1;
    end else if (rise_s[2]) begin
      dir_ev_s   = 1'b1;
      dir_code_s = 2'd2;
    end else if (rise_s[3]) begin
      dir_ev_s   = 1'b1;
      dir_code_s = 2'd3;
    end else if (rise_s[4]) begin
      ctr_ev_s = 1'b1;
    end else begin
      dir_ev_s = 1'b0;
    end
  end

  // Decode the current heading; idle/restart has no reference direction.
  always_comb begin
    go_ref_vld_s  = 1'b1;
    go_ref_code_s = 2'd0;
    case (go_q)
      5'b00001: go_ref_code_s = 2'd0;
      5'b00010: go_ref_code_s = 2'd1;
      5'b00100: go_ref_code_s = 2'd2;
      5'b01000: go_ref_code_s = 2'd3;
      default:  go_ref_vld_s  = 1'b0;
    endcase
  end

  assign tail_code_s = mem_q[wr_q - PW'(1)];
  assign ref_vld_s   = (q_count_q != '0) || go_ref_vld_s;
  assign ref_code_s  = (q_count_q != '0) ? tail_code_s : go_ref_code_s;
  assign dup_s       = ref_vld_s && (dir_code_s == ref_code_s);
`ifdef SNAKE_DIR_REVERSE_EN
  assign rev_s       = 1'b0;
`else
  assign rev_s       = ref_vld_s && (dir_code_s == (ref_code_s ^ 2'b01));
`endif
  assign accept_s    = dir_ev_s && !dup_s && !rev_s;
  assign full_s      = (q_count_q == NW'(QUEUE_DEPTH));
  assign push_s      = accept_s && !full_s;
  assign pop_s       = tick && (q_count_q != '0);

  // Command queue, heading update and status flags; center overrides any tick.
  always_comb begin
    mem_d      = mem_q;
    rd_d       = rd_q;
    wr_d       = wr_q;
    q_count_d  = q_count_q;
    go_d       = go_q;
    restart_d  = 1'b0;
    overflow_d = overflow_q;
    if (ctr_ev_s) begin
      rd_d       = wr_q;
      q_count_d  = '0;
      go_d       = 5'b10000;
      restart_d  = 1'b1;
      overflow_d = 1'b0;
    end else begin
      if (push_s) begin
        mem_d[wr_q] = dir_code_s;
        wr_d        = wr_q + PW'(1);
      end else begin
        wr_d = wr_q;
      end
      if (pop_s) begin
        go_d = dir_onehot(mem_q[rd_q]);
        rd_d = rd_q + PW'(1);
      end else begin
        rd_d = rd_q;
      end
      if (accept_s && full_s) begin
        overflow_d = 1'b1;
      end else begin
        overflow_d = overflow_q;
      end
      q_count_d = q_count_q + NW'(push_s) - NW'(pop_s);
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q    <= 5'b00000;
      sync2_q    <= 5'b00000;
      deb_q      <= 5'b00000;
      deb_dly_q  <= 5'b00000;
      for (int i = 0; i < 5; i++) cnt_q[i] <= '0;
      for (int j = 0; j < QUEUE_DEPTH; j++) mem_q[j] <= 2'd0;
      rd_q       <= '0;
      wr_q       <= '0;
      q_count_q  <= '0;
      go_q       <= 5'b00000;
      restart_q  <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      deb_q      <= deb_d;
      deb_dly_q  <= deb_dly_d;
      cnt_q      <= cnt_d;
      mem_q      <= mem_d;
      rd_q       <= rd_d;
      wr_q       <= wr_d;
      q_count_q  <= q_count_d;
      go_q       <= go_d;
      restart_q  <= restart_d;
      overflow_q <= overflow_d;
    end
  end

  assign go            = go_q;
  assign restart_pulse = restart_q;
  assign q_count       = q_count_q;
  assign overflow      = overflow_q;

endmodule

// File: tb/tb_snake_dir_ctrl.sv
// Bench for snake_dir_ctrl: directed scenarios plus random button/tick traffic against a queue-based model.
module tb_snake_dir_ctrl;

  localparam int D  = 4;
  localparam int QD = 4;
  localparam int HL = D + 1;

  logic       clk = 1'b0;
  logic       rst_n, up, down, left, right, center, tick;
  logic [4:0] go;
  logic       restart_pulse;
  logic [2:0] q_count;
  logic       overflow;

  int n_vec = 0;
  int n_err = 0;

  // Model state: raw sample history, debounced levels, pending rises, command list.
  bit h     [5][HL];
  bit mdeb  [5];
  bit mpend [5];
  int mq[$];
  int mgo, mrp, mov;

  snake_dir_ctrl #(.DEBOUNCE_CYCLES(D), .QUEUE_DEPTH(QD)) dut (
    .clk(clk), .rst_n(rst_n), .up(up), .down(down), .left(left), .right(right),
    .center(center), .tick(tick), .go(go), .restart_pulse(restart_pulse),
    .q_count(q_count), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int opposite(input int d);
    case (d)
      0: return 1;
      1: return 0;
      2: return 3;
      default: return 2;
    endcase
  endfunction

  task automatic model_edge();
    logic [4:0] raw;
    int  sel, refd;
    bit  has_ref, acc, full, flip;
    bit  np [5];
    raw = {center, right, left, down, up};
    if (!rst_n) begin
      mgo = 0; mrp = 0; mov = 0;
      mq.delete();
      for (int b = 0; b < 5; b++) begin
        mdeb[b] = 1'b0; mpend[b] = 1'b0;
        for (int i = 0; i < HL; i++) h[b][i] = 1'b0;
      end
      return;
    end
    sel = -1;
    for (int b = 0; b < 5; b++) if (mpend[b] && sel < 0) sel = b;
    mrp = 0;
    if (sel == 4) begin
      mq.delete(); mgo = 16; mrp = 1; mov = 0;
    end else begin
      acc  = 1'b0;
      full = (mq.size() >= QD);
      if (sel >= 0) begin
        has_ref = 1'b1; refd = 0;
        if (mq.size() > 0) refd = mq[$];
        else if (mgo == 1) refd = 0;
        else if (mgo == 2) refd = 1;
        else if (mgo == 4) refd = 2;
        else if (mgo == 8) refd = 3;
        else has_ref = 1'b0;
        acc = 1'b1;
        if (has_ref && sel == refd) acc = 1'b0;
`ifndef SNAKE_DIR_REVERSE_EN
        if (has_ref && sel == opposite(refd)) acc = 1'b0;
`endif
      end
      if (tick && mq.size() > 0) mgo = 1 << mq.pop_front();
      if (acc) begin
        if (!full) mq.push_back(sel);
        else mov = 1;
      end
    end
    // A level flips once the synchronised value (raw two edges back) has differed for D edges.
    for (int b = 0; b < 5; b++) begin
      flip = 1'b1;
      for (int i = 0; i < D; i++) if (h[b][i+1] == mdeb[b]) flip = 1'b0;
      np[b] = flip && !mdeb[b];
      if (flip) mdeb[b] = ~mdeb[b];
      for (int i = HL - 1; i > 0; i--) h[b][i] = h[b][i-1];
      h[b][0] = raw[b];
    end
    for (int b = 0; b < 5; b++) mpend[b] = np[b];
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_eq("go", {27'd0, go}, mgo);
    check_eq("restart_pulse", {31'd0, restart_pulse}, mrp);
    check_eq("q_count", {29'd0, q_count}, mq.size());
    check_eq("overflow", {31'd0, overflow}, mov);
  endtask

  task automatic hold_cycles(input int n, input bit rnd_tick);
    for (int i = 0; i < n; i++) begin
      tick = rnd_tick ? ($urandom_range(0, 3) == 0) : 1'b0;
      step();
    end
    tick = 1'b0;
  endtask

  task automatic set_btn(input logic [4:0] m);
    {center, right, left, down, up} = m;
  endtask

  task automatic press(input logic [4:0] m);
    set_btn(m);
    hold_cycles(8, 1'b0);
    set_btn(5'b00000);
    hold_cycles(8, 1'b0);
  endtask

  task automatic pulse_tick();
    tick = 1'b1;
    step();
    tick = 1'b0;
  endtask

  initial begin
    int r, hold, rel;
    logic [4:0] m;
    rst_n = 1'b0; tick = 1'b0;
    set_btn(5'b00000);
    step(); step();
    rst_n = 1'b1;
    check_eq("rst_go", {27'd0, go}, 32'd0);
    check_eq("rst_qc", {29'd0, q_count}, 32'd0);
    check_eq("rst_ovf", {31'd0, overflow}, 32'd0);
    check_eq("rst_rp", {31'd0, restart_pulse}, 32'd0);

    // Up press latency, single event while held.
    set_btn(5'b00001);
    hold_cycles(6, 1'b0);
    check_eq("up_lat_early", {29'd0, q_count}, 32'd0);
    step();
    check_eq("up_lat", {29'd0, q_count}, 32'd1);
    hold_cycles(3, 1'b0);
    pulse_tick();
    check_eq("up_tick_go", {27'd0, go}, 32'd1);
    check_eq("up_tick_qc", {29'd0, q_count}, 32'd0);
    hold_cycles(6, 1'b0);
    check_eq("held_no_repeat", {29'd0, q_count}, 32'd0);
    set_btn(5'b00000);
    hold_cycles(8, 1'b0);

    // Short glitch is filtered.
    set_btn(5'b00010);
    hold_cycles(3, 1'b0);
    set_btn(5'b00000);
    hold_cycles(10, 1'b0);
    check_eq("glitch_qc", {29'd0, q_count}, 32'd0);

    // Reversal filter from heading up.
    press(5'b00010);
`ifdef SNAKE_DIR_REVERSE_EN
    check_eq("rev_push_qc", {29'd0, q_count}, 32'd1);
    pulse_tick();
    check_eq("rev_go_down", {27'd0, go}, 32'd2);
`else
    check_eq("reversal_qc", {29'd0, q_count}, 32'd0);
`endif
    press(5'b00100);
    press(5'b00010);
    check_eq("two_push_qc", {29'd0, q_count}, 32'd2);
    pulse_tick();
    check_eq("tick1_go", {27'd0, go}, 32'd4);
    pulse_tick();
    check_eq("tick2_go", {27'd0, go}, 32'd2);

    // Fill the queue, overflow, then restart.
    press(5'b00100); press(5'b00001); press(5'b01000); press(5'b00010); press(5'b00100);
    check_eq("full_qc", {29'd0, q_count}, 32'd4);
    check_eq("full_ovf", {31'd0, overflow}, 32'd1);
    set_btn(5'b10000);
    hold_cycles(6, 1'b0);
    check_eq("ctr_rp_early", {31'd0, restart_pulse}, 32'd0);
    step();
    check_eq("ctr_rp", {31'd0, restart_pulse}, 32'd1);
    check_eq("ctr_qc", {29'd0, q_count}, 32'd0);
    check_eq("ctr_go", {27'd0, go}, 32'd16);
    check_eq("ctr_ovf", {31'd0, overflow}, 32'd0);
    step();
    check_eq("ctr_rp_once", {31'd0, restart_pulse}, 32'd0);
    set_btn(5'b00000);
    hold_cycles(8, 1'b0);

    // Simultaneous up+right: up wins.
    press(5'b01001);
    check_eq("prio_qc", {29'd0, q_count}, 32'd1);
    pulse_tick();
    check_eq("prio_go", {27'd0, go}, 32'd1);
    press(5'b00100);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check_eq("midrst_go", {27'd0, go}, 32'd0);
    check_eq("midrst_qc", {29'd0, q_count}, 32'd0);
    check_eq("midrst_ovf", {31'd0, overflow}, 32'd0);

    // Random traffic.
    for (int s = 0; s < 300; s++) begin
      r = $urandom_range(0, 99);
      if (r < 3) begin
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
      end else begin
        m = 5'b00001 << $urandom_range(0, 3);
        if (r < 15) m = m | (5'b00001 << $urandom_range(0, 3));
        if (r >= 95) m = 5'b10000;
        hold = $urandom_range(1, 10);
        rel  = $urandom_range(1, 8);
        set_btn(m);
        hold_cycles(hold, 1'b1);
        set_btn(5'b00000);
        hold_cycles(rel, 1'b1);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
